// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES equal slices,
// and each slice is registered behind a single global valid/ready stall.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int WS = WIDTH / STAGES;

  logic                          advance;
  logic [STAGES-1:0][WIDTH-1:0]  a_r, b_r, s_r;
  logic [STAGES-1:0][WIDTH-1:0]  a_nxt, b_nxt, s_nxt;
  logic [STAGES-1:0]             c_r, v_r, c_nxt, v_nxt;
  logic                          ovf_r, ovf_nxt;
  logic                          unused_bits;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] pa, pb, ps, s_loc;
    logic             pc, pv;
    logic [WS:0]      part;

    if (k == 0) begin : g_first
      // b is inverted once on entry; the +1 of subtract rides in as carry-in.
      assign pa = a;
      assign pb = sub ? ~b : b;
      assign ps = '0;
      assign pc = sub | cin;
      assign pv = in_valid;
    end else begin : g_next
      assign pa = a_r[k-1];
      assign pb = b_r[k-1];
      assign ps = s_r[k-1];
      assign pc = c_r[k-1];
      assign pv = v_r[k-1];
    end

    assign part = {1'b0, pa[k*WS +: WS]} + {1'b0, pb[k*WS +: WS]} + {{WS{1'b0}}, pc};

    always_comb begin
      s_loc = ps;
      s_loc[k*WS +: WS] = part[WS-1:0];
    end

    assign a_nxt[k] = pa;
    assign b_nxt[k] = pb;
    assign s_nxt[k] = s_loc;
    assign c_nxt[k] = part[WS];
    assign v_nxt[k] = pv;
  end

  assign ovf_nxt = (a_nxt[STAGES-1][WIDTH-1] == b_nxt[STAGES-1][WIDTH-1]) &&
                   (s_nxt[STAGES-1][WIDTH-1] != a_nxt[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= '0;
      v_r   <= '0;
      ovf_r <= 1'b0;
    end else if (advance) begin
      a_r   <= a_nxt;
      b_r   <= b_nxt;
      s_r   <= s_nxt;
      c_r   <= c_nxt;
      v_r   <= v_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

  // Operand slices already consumed are dead; synthesis trims them.
  assign unused_bits = ^{a_r, b_r};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed boundary vectors, back-to-back
// traffic, random stalls and mid-flight reset.
module tb_pipelined_adder #(parameter int STAGES = 4);

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  localparam logic [31:0] VA   [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h5, 32'h0, 32'h7};
  localparam logic [31:0] VB   [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h7, 32'h0, 32'h7};
  localparam logic        VC   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic        VS   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] VSUM [6] = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h0};
  localparam logic        VCO  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic        VOV  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Golden model: returns {ovf, cout, sum}, signed overflow from a wide exact result.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                             input logic c, input logic s);
    logic [WIDTH-1:0] rs;
    logic             co;
    logic [WIDTH+1:0] wide;
    logic             ov;
    if (s) begin
      rs   = aa - bb;
      co   = (aa >= bb);
      wide = {{2{aa[WIDTH-1]}}, aa} - {{2{bb[WIDTH-1]}}, bb};
    end else begin
      {co, rs} = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
      wide = {{2{aa[WIDTH-1]}}, aa} + {{2{bb[WIDTH-1]}}, bb} + {{(WIDTH+1){1'b0}}, c};
    end
    ov = !(wide[WIDTH+1:WIDTH-1] == 3'b000 || wide[WIDTH+1:WIDTH-1] == 3'b111);
    return {ov, co, rs};
  endfunction

  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                             input logic c, input logic s, input logic ordy,
                             output logic ov, output logic ir, output logic [WIDTH-1:0] os,
                             output logic oc, output logic oo, output int tnow);
    logic [WIDTH+1:0] m;
    @(negedge clk);
    in_valid = iv; a = aa; b = bb; cin = c; sub = s; out_ready = ordy;
    #1;
    ov = out_valid; ir = in_ready; os = sum; oc = cout; oo = ovf; tnow = cyc;
    if (in_valid && in_ready) begin
      m = model(aa, bb, c, s);
      q.push_back('{sum: m[WIDTH-1:0], cout: m[WIDTH], ovf: m[WIDTH+1], t: cyc});
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h want=0", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_boundary();
    logic ov, ir, oc, oo, seen;
    logic [WIDTH-1:0] os;
    int tnow, tacc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, VA[i], VB[i], VC[i], VS[i], 1'b1, ov, ir, os, oc, oo, tacc);
      checks++; if (ir !== 1'b1) begin failures++; $display("FAIL bnd_accept[%0d] in_ready=%b want=1", i, ir); end
      seen = 1'b0;
      for (int j = 0; j < STAGES + 5 && !seen; j++) begin
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, ir, os, oc, oo, tnow);
        if (ov) begin
          seen = 1'b1;
          if (q.size() > 0) e = q.pop_front();
          checks++;
          if ({os, oc, oo} !== {VSUM[i], VCO[i], VOV[i]}) begin
            failures++;
            $display("FAIL bnd_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, os, oc, oo, VSUM[i], VCO[i], VOV[i]);
          end
          checks++;
          if (tnow - tacc != STAGES) begin
            failures++; $display("FAIL bnd_latency[%0d] got=%0d want=%0d", i, tnow - tacc, STAGES);
          end
        end
      end
      if (!seen) begin
        checks++; failures++; $display("FAIL bnd_timeout[%0d] out_valid never 1 want result", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ov, ir, oc, oo;
    logic [WIDTH-1:0] os;
    int tnow, delivered;
    exp_t e;
    delivered = 0;
    for (int i = 0; i < 100 + STAGES + 4; i++) begin
      if (i < 100)
        drive_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                    1'b1, ov, ir, os, oc, oo, tnow);
      else
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, ir, os, oc, oo, tnow);
      if (i < 100) begin
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", i, ir); end
      end
      if (ov) begin
        delivered++;
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra cyc=%0d got unexpected beat sum=%h want none", i, os);
        end else begin
          e = q.pop_front();
          if ({os, oc, oo} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL b2b_data got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     os, oc, oo, e.sum, e.cout, e.ovf);
          end
          checks++;
          if (tnow - e.t != STAGES) begin
            failures++; $display("FAIL b2b_latency got=%0d want=%0d", tnow - e.t, STAGES);
          end
        end
      end
    end
    checks++; if (delivered != 100) begin failures++; $display("FAIL b2b_count got=%0d want=100", delivered); end
  endtask

  task automatic test_random_stall();
    logic ov, ir, oc, oo, iv, ordy, prev_stall, done;
    logic [WIDTH-1:0] os, ps;
    logic pc, po;
    int tnow;
    exp_t e;
    prev_stall = 1'b0; ps = '0; pc = 1'b0; po = 1'b0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      iv   = (i < 300) && ($urandom_range(0, 9) < 7);
      ordy = (i < 300) ? 1'($urandom) : 1'b1;
      drive_cycle(iv, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  ordy, ov, ir, os, oc, oo, tnow);
      checks++;
      if (ir !== !(ov && !ordy)) begin
        failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=%b", i, ir, !(ov && !ordy));
      end
      if (prev_stall) begin
        checks++;
        if ({ov, os, oc, oo} !== {1'b1, ps, pc, po}) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                   i, ov, os, oc, oo, ps, pc, po);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stall_extra cyc=%0d got unexpected beat sum=%h want none", i, os);
        end else begin
          e = q.pop_front();
          if ({os, oc, oo} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL stall_data got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     os, oc, oo, e.sum, e.cout, e.ovf);
          end
        end
      end
      prev_stall = ov && !ordy; ps = os; pc = oc; po = oo;
      if (i >= 300 && q.size() == 0 && !ov) done = 1'b1;
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL stall_lost got=%0d pending want=0", q.size()); end
  endtask

  task automatic test_reset_mid();
    logic ov, ir, oc, oo, seen;
    logic [WIDTH-1:0] os;
    int tnow;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, WIDTH'($urandom) | 32'h1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, ov, ir, os, oc, oo, tnow);
    seen = 1'b0;
    for (int j = 0; j < STAGES + 2 && !seen; j++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ov, ir, os, oc, oo, tnow);
      seen = ov;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstmid_fill out_valid=%b want=1 before reset", ov); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    checks++; if ({sum, cout, ovf} !== '0) begin failures++; $display("FAIL rstmid_sum got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf); end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < STAGES + 3; j++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, ir, os, oc, oo, tnow);
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d out_valid=%b want=0", j, ov); end
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
